dmem_responder: RTL and testbench

- Data-memory responder for the 16-bit pipelined CPU; the memory side of the load/store interface the memory stage drives.
- Accepts one load or store request per handshake and inserts a configurable number of wait states, so slower memories can be modelled.
- Returns read data with a one-cycle valid strobe and drives a stall signal the pipeline uses to freeze the M/W registers while an access is in flight.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default widths.
`default_nettype none

package dmem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int BUS_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// Synchronous single-port RAM; read data is registered and only updates on reads.
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// Load/store responder for the pipelined CPU memory stage, with a configurable
// number of wait states between request acceptance and the one-cycle response.
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [BUS_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  stall
);

  localparam logic [3:0] WS_INIT  = 4'(WAIT_STATES);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic                    lat_we;
  logic [BUS_ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]       lat_wdata;
  logic                    acc_we;
  logic [BUS_ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]       acc_wdata;
  logic                    in_range;
  logic                    commit;
  logic                    mem_en;
  logic                    rdata_zero;
  logic                    err_q;
  logic [DATA_W-1:0]       ram_rdata;

  // With zero wait states the access commits on the accepting edge, so the
  // live request must reach the RAM before it has been latched.
  assign acc_we    = (state == IDLE) ? we    : lat_we;
  assign acc_addr  = (state == IDLE) ? addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? wdata : lat_wdata;
  assign in_range  = ((acc_addr >> ADDR_W) == '0);

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    stall     = 1'b0;
    rvalid    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req && HAS_WAIT;
        if (req) begin
          state_nx = HAS_WAIT ? WAIT : RESP;
          commit   = !HAS_WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        rvalid   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en = commit && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      err_q      <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      state <= state_nx;
      err_q <= 1'b0;
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        cnt       <= WS_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= !in_range;
        if (!in_range)   rdata_zero <= 1'b1;
        else if (!acc_we) rdata_zero <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc_we),
    .addr  (acc_addr[ADDR_W-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset; mask it until a real load lands.
  assign rdata = rdata_zero ? '0 : ram_rdata;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder; instance 0 has two wait
//               states, instance 1 none.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [2];
    logic        we [2];
    logic [15:0] addr [2];
    logic [15:0] wdata [2];
    logic        req_ready [2];
    logic        rvalid [2];
    logic [15:0] rdata [2];
    logic        err [2];
    logic        stall [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .req_ready(req_ready[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
        .err(err[0]), .stall(stall[0])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .req_ready(req_ready[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
        .err(err[1]), .stall(stall[1])
    );

    // Issues one request from an IDLE negedge and returns at the negedge after RESP.
    task automatic access(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output logic e, output int lat, output int stl,
                          output logic stall_req, output logic ok);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        #1 stall_req = stall[d];
        @(negedge clk);
        req[d] = 1'b0;
        lat = 1; stl = 0;
        while (rvalid[d] !== 1'b1 && lat < 40) begin
            if (stall[d] === 1'b1) stl++;
            @(negedge clk);
            lat++;
        end
        ok = (rvalid[d] === 1'b1);
        rd = rdata[d];
        e  = err[d];
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] rd; logic e, sr, ok; int lat, stl;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rvalid[d] !== 1'b0 || rdata[d] !== 16'h0 ||
                err[d] !== 1'b0 || stall[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_init dut%0d: ready=%b rvalid=%b rdata=%h err=%b stall=%b, want 1 0 0000 0 0",
                         d, req_ready[d], rvalid[d], rdata[d], err[d], stall[d]);
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        access(0, 1'b1, 16'h0010, 16'h1234, rd, e, lat, stl, sr, ok);
        access(0, 1'b0, 16'h0010, 16'h0000, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || rd !== 16'h1234) begin
            errors++;
            $display("FAIL reset_setup_load: got %h ok=%b, want 1234", rd, ok);
        end

        // Abort a store while it is in WAIT.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'hDEAD;
        @(negedge clk);
        req[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_ready[0] !== 1'b1 || rvalid[0] !== 1'b0 || rdata[0] !== 16'h0 ||
            err[0] !== 1'b0 || stall[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: ready=%b rvalid=%b rdata=%h err=%b stall=%b, want 1 0 0000 0 0",
                     req_ready[0], rvalid[0], rdata[0], err[0], stall[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 16'h0010, 16'h0000, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || rd !== 16'h1234) begin
            errors++;
            $display("FAIL reset_store_aborted: got %h, want 1234", rd);
        end

        // Reset during RESP must not undo the committed store.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'h7777;
        @(negedge clk);
        req[0] = 1'b0;
        for (int i = 0; i < 10 && rvalid[0] !== 1'b1; i++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_resp_rvalid: got %b, want 0", rvalid[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 16'h0020, 16'h0000, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || rd !== 16'h7777) begin
            errors++;
            $display("FAIL reset_in_resp_kept: got %h, want 7777", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] rd; logic e, sr, ok; int lat, stl;
        access(0, 1'b1, 16'h0004, 16'h00A5, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || lat != 3 || stl != 2 || sr !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL ws2_store: ok=%b lat=%0d stalls=%0d stall_req=%b err=%b, want 1 3 2 1 0",
                     ok, lat, stl, sr, e);
        end
        access(0, 1'b0, 16'h0004, 16'h0000, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || lat != 3 || stl != 2 || sr !== 1'b1 || e !== 1'b0 || rd !== 16'h00A5) begin
            errors++;
            $display("FAIL ws2_load: ok=%b lat=%0d stalls=%0d stall_req=%b err=%b rdata=%h, want 1 3 2 1 0 00a5",
                     ok, lat, stl, sr, e, rd);
        end
        checks++;
        if (rdata[0] !== 16'h00A5 || rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ws2_rdata_hold: rdata=%h rvalid=%b, want 00a5 0", rdata[0], rvalid[0]);
        end
    endtask

    task automatic test_zero_wait();
        logic [15:0] rd; logic e, sr, ok; int lat, stl;
        access(1, 1'b1, 16'h0001, 16'h1111, rd, e, lat, stl, sr, ok);
        access(1, 1'b1, 16'h0002, 16'h2222, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || lat != 1 || sr !== 1'b0) begin
            errors++;
            $display("FAIL ws0_store: ok=%b lat=%0d stall_req=%b, want 1 1 0", ok, lat, sr);
        end
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
        #1;
        checks++;
        if (stall[1] !== 1'b0) begin
            errors++;
            $display("FAIL ws0_stall_req: got %b, want 0", stall[1]);
        end
        @(negedge clk);
        checks++;
        if (rvalid[1] !== 1'b1 || rdata[1] !== 16'h1111 || stall[1] !== 1'b0) begin
            errors++;
            $display("FAIL ws0_first: rvalid=%b rdata=%h stall=%b, want 1 1111 0", rvalid[1], rdata[1], stall[1]);
        end
        addr[1] = 16'h0002;
        @(negedge clk);
        checks++;
        if (rvalid[1] !== 1'b0 || req_ready[1] !== 1'b1 || stall[1] !== 1'b0) begin
            errors++;
            $display("FAIL ws0_gap: rvalid=%b ready=%b stall=%b, want 0 1 0", rvalid[1], req_ready[1], stall[1]);
        end
        @(negedge clk);
        checks++;
        if (rvalid[1] !== 1'b1 || rdata[1] !== 16'h2222 || stall[1] !== 1'b0) begin
            errors++;
            $display("FAIL ws0_second: rvalid=%b rdata=%h stall=%b, want 1 2222 0", rvalid[1], rdata[1], stall[1]);
        end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd; logic e, sr, ok; int lat, stl;
        access(0, 1'b1, 16'h0000, 16'h0000, rd, e, lat, stl, sr, ok);
        access(0, 1'b1, 16'h0100, 16'hBEEF, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || e !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL oor_err: ok=%b err=%b lat=%0d, want 1 1 3", ok, e, lat);
        end
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_clear: got %b, want 0", err[0]);
        end
        access(0, 1'b0, 16'h0000, 16'h0000, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || rd !== 16'h0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL oor_no_write: rdata=%h err=%b, want 0000 0", rd, e);
        end
    endtask

    task automatic test_req_held();
        int pulses = 0, readies = 0, bad = 0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0004;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rvalid[0] === 1'b1) begin
                pulses++;
                if (rdata[0] !== 16'h00A5) bad++;
            end
            if (req_ready[0] === 1'b1) readies++;
        end
        req[0] = 1'b0;
        checks++;
        if (pulses != 2 || readies != 2 || bad != 0) begin
            errors++;
            $display("FAIL req_held: pulses=%0d readies=%0d bad_data=%0d, want 2 2 0", pulses, readies, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [15:0] rd; logic e, sr, ok; int lat, stl;
        access(0, 1'b1, 16'h00FF, 16'h5A5A, rd, e, lat, stl, sr, ok);
        access(0, 1'b0, 16'h00FF, 16'h0000, rd, e, lat, stl, sr, ok);
        checks++;
        if (!ok || rd !== 16'h5A5A || e !== 1'b0) begin
            errors++;
            $display("FAIL wrap: rdata=%h err=%b, want 5a5a 0", rd, e);
        end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_zero_wait();
        test_out_of_range();
        test_req_held();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
